sif_address_arb: RTL
====================

Name: sif_address_arb

Overview:
- Round-robin arbiter and sequencer that shares one sif_address serial-addressing engine among NREQ requesters.
- Each requester presents its own tx_add_1/tx_add_2/rx_add/mode set. The arbiter grants one requester, loads that set into the engine, pulses the engine enable, then waits for done/err or a timeout.
- It returns a per-requester ack or nack pulse.
- Sits between the client blocks and the sif_address instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- EN_HOLD, 1, cycles sif_en_o is held high per transaction (1..15).
- TIMEOUT, 64, cycles from transaction start without done/err before forced nack (>EN_HOLD, <=255).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NREQ  request per requester, level.
- tx_add_1_i  in  4*NREQ  requester k uses bits [4k+3:4k].
- tx_add_2_i  in  4*NREQ  same packing.
- rx_add_i  in  4*NREQ  same packing.
- mode_i  in  NREQ  mode per requester.
- gnt_o  out  NREQ  one-hot grant, high for the whole transaction.
- ack_o  out  NREQ  1-cycle pulse, transaction done without error.
- nack_o  out  NREQ  1-cycle pulse, engine error or timeout.
- timeout_o  out  1  1-cycle pulse, coincident with a nack caused by timeout.
- busy_o  out  1  high when state != IDLE.
- sif_tx_add_1_o  out  4  to engine tx_add_1_i.
- sif_tx_add_2_o  out  4  to engine tx_add_2_i.
- sif_rx_add_o  out  4  to engine rx_add_i.
- sif_mode_o  out  1  to engine mode_i.
- sif_en_o  out  1  to engine en_i.
- sif_done_i  in  1  from engine done_o.
- sif_err_i  in  1  from engine err_o.

Behaviour:
- All outputs are registered.
- Reset (rst_i high at a rising edge):
  - State = IDLE; every output = 0.
  - Priority pointer last = NREQ-1, so requester 0 has highest priority after reset.
  - Timeout counter = 0.
- A reset asserted mid-transaction aborts it silently: no ack/nack is issued, and sif_en_o drops on the next cycle.
- FSM states are IDLE, START, WAIT, RESP.
- IDLE:
  - If req_i != 0, select the first set bit searching last+1, last+2, ... modulo NREQ.
  - Register gnt_o one-hot, and copy that requester's address fields and mode into sif_*_o.
  - Set sif_en_o = 1, clear the counter, and go to START.
  - Grant and enable appear 1 cycle after req is sampled.
  - If req_i == 0, stay in IDLE.
- START:
  - sif_en_o stays high for EN_HOLD cycles total, then the FSM goes to WAIT and sif_en_o = 0.
- WAIT:
  - Wait for a response from the engine.
- Counter and addresses:
  - The counter increments every cycle in START and WAIT.
  - sif_*_o address/mode fields are held constant from grant until IDLE is re-entered. Requester input changes after grant are ignored.
- Response detection (sif_done_i, sif_err_i sampled in both START and WAIT):
  - err = 1 -> RESP with nack.
  - err = 0 and done = 1 -> RESP with ack.
  - done and err in the same cycle -> nack (err wins).
  - Counter reaching TIMEOUT-1 with neither asserted -> RESP with nack and timeout_o.
  - A response on the counter's final cycle takes precedence over the timeout.
- RESP:
  - ack_o[g] or nack_o[g] is high for exactly 1 cycle; timeout_o likewise if applicable.
  - gnt_o is still high in this cycle.
  - sif_en_o is forced 0 on entry to RESP, even if EN_HOLD has not expired.
  - last <= g; gnt_o clears; go to IDLE.
- Back-to-back transactions pass through at least 1 IDLE cycle.
- sif_done_i/sif_err_i are ignored in IDLE and RESP.
- Requester rules:
  - A requester drops req_i after its ack/nack.
  - If req_i is still high, it re-competes with lowest priority (round-robin fairness).
  - Dropping req_i while granted does not abort; the response is still issued.
  - A request arriving during a transaction waits; no request is lost while it is held high.
- Invariants:
  - At most one gnt_o bit is set.
  - ack_o and nack_o are never both set.
  - ack_o/nack_o are only ever set at the granted index.

Test Plan:
- Reset, then req_i = 0001 with fields 0000/1111/1010, mode 0, engine model returns done 12 cycles after en:
  - gnt_o = 0001 one cycle after req.
  - sif_en_o high for 1 cycle.
  - sif fields = 0000/1111/1010.
  - ack_o = 0001 for one cycle; busy_o low after it.
- req_i = 0101 held, requester 2 fields 0010/1101/1001, engine done after 12 cycles:
  - Grant order is 0, 2, 0, 2.
  - sif fields switch to 0010/1101/1001 on each grant of requester 2.
- Engine asserts err 5 cycles into the transaction for requester 3 -> nack_o = 1000 for 1 cycle, ack_o stays 0, timeout_o = 0.
- Engine never responds, TIMEOUT = 64 -> nack_o and timeout_o pulse exactly 64 cycles after sif_en_o rose; sif_en_o has already dropped.
- done and err asserted in the same cycle -> nack only. Separately, done on the final counter cycle -> ack and no timeout_o.
- rst_i pulsed during WAIT with req_i = 1111 held:
  - All outputs 0 the next cycle, with no ack/nack.
  - The first grant after reset = 0001.

Source files
------------

// File: rtl/sif_address_arb.sv
// sif_address_arb: round-robin arbiter sharing one sif_address engine among NREQ requesters
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_i[NREQ]               level requests
//   tx_add_1_i/tx_add_2_i/rx_add_i [4*NREQ]  per-requester fields, requester k at [4k+3:4k]
//   mode_i[NREQ]              per-requester mode
//   gnt_o/ack_o/nack_o[NREQ]  one-hot grant, 1-cycle ack / nack pulses
//   timeout_o, busy_o         timeout pulse (with its nack), not-idle flag
//   sif_*_o, sif_en_o         fields and enable to the engine
//   sif_done_i, sif_err_i     engine response
module sif_address_arb #(
    parameter int NREQ    = 4,
    parameter int EN_HOLD = 1,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [4*NREQ-1:0] tx_add_1_i,
    input  logic [4*NREQ-1:0] tx_add_2_i,
    input  logic [4*NREQ-1:0] rx_add_i,
    input  logic [NREQ-1:0]   mode_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   ack_o,
    output logic [NREQ-1:0]   nack_o,
    output logic              timeout_o,
    output logic              busy_o,
    output logic [3:0]        sif_tx_add_1_o,
    output logic [3:0]        sif_tx_add_2_o,
    output logic [3:0]        sif_rx_add_o,
    output logic              sif_mode_o,
    output logic              sif_en_o,
    input  logic              sif_done_i,
    input  logic              sif_err_i
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] last_q, last_d, g_q, g_d, sel;
    logic [7:0] cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d, nack_q, nack_d;
    logic tmo_q, tmo_d, busy_q, busy_d, en_q, en_d, mode_q, mode_d;
    logic [3:0] tx1_q, tx1_d, tx2_q, tx2_d, rx_q, rx_d;
    logic active, fire, tmo, fin;

    // Scan offsets from far to near so the requester closest after last_q is the one left in sel.
    always_comb begin
        sel = last_q;
        for (int i = NREQ; i >= 1; i--) begin
            int j;
            j = (int'(last_q) + i) % NREQ;
            if (req_i[j]) sel = IW'(j);
        end
    end

    assign active = state_q == START || state_q == WAIT;
    assign fire   = state_q == IDLE && |req_i;
    assign tmo    = cnt_q == 8'(TIMEOUT - 1);
    assign fin    = active && (sif_err_i || sif_done_i || tmo);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE  ? (fire ? START : IDLE)
                : fin              ? RESP
                : state_q == START ? (cnt_q == 8'(EN_HOLD - 1) ? WAIT : START)
                : state_q == RESP  ? IDLE
                : state_q;
    end

    // An engine response on the counter's last cycle outranks the timeout; err outranks done.
    always_comb begin
        gnt_d  = fire ? {{(NREQ-1){1'b0}}, 1'b1} << sel : state_q == RESP ? '0 : gnt_q;
        ack_d  = (fin && !sif_err_i && sif_done_i) ? gnt_q : '0;
        nack_d = (fin && (sif_err_i || !sif_done_i)) ? gnt_q : '0;
        tmo_d  = fin && !sif_err_i && !sif_done_i;
        busy_d = state_d != IDLE;
        en_d   = state_d == START;
        cnt_d  = fire ? '0 : active ? cnt_q + 8'd1 : cnt_q;
        g_d    = fire ? sel : g_q;
        last_d = state_q == RESP ? g_q : last_q;
        tx1_d  = fire ? tx_add_1_i[4*sel +: 4] : tx1_q;
        tx2_d  = fire ? tx_add_2_i[4*sel +: 4] : tx2_q;
        rx_d   = fire ? rx_add_i[4*sel +: 4] : rx_q;
        mode_d = fire ? mode_i[sel] : mode_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q  <= '0;
            ack_q  <= '0;
            nack_q <= '0;
            tmo_q  <= 1'b0;
            busy_q <= 1'b0;
            en_q   <= 1'b0;
            cnt_q  <= '0;
            g_q    <= '0;
            last_q <= IW'(NREQ - 1);
            tx1_q  <= '0;
            tx2_q  <= '0;
            rx_q   <= '0;
            mode_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            ack_q  <= ack_d;
            nack_q <= nack_d;
            tmo_q  <= tmo_d;
            busy_q <= busy_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            g_q    <= g_d;
            last_q <= last_d;
            tx1_q  <= tx1_d;
            tx2_q  <= tx2_d;
            rx_q   <= rx_d;
            mode_q <= mode_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign ack_o          = ack_q;
    assign nack_o         = nack_q;
    assign timeout_o      = tmo_q;
    assign busy_o         = busy_q;
    assign sif_en_o       = en_q;
    assign sif_tx_add_1_o = tx1_q;
    assign sif_tx_add_2_o = tx2_q;
    assign sif_rx_add_o   = rx_q;
    assign sif_mode_o     = mode_q;
endmodule
